// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed seven-segment scan driver
// Latches packed digit nibbles and scans them onto a common-anode display.
module seg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int CLK_DIV  = 1000,
  parameter int HEX_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  on,
  input  logic                  en,
  input  logic                  set,
  input  logic                  blank_lz,
  input  logic [4*DIGITS-1:0]   data,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_ALL  = 7'h00;
  localparam logic [6:0] SEG_ERR  = 7'b0111111;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                fd_q, fd_d;

  logic                tick;
  logic [3:0]          nib;
  logic [DIGITS-1:0]   upper_zero;
  logic                zero_run;
  logic                cur_zero;
  logic                blank_slot;
  logic [DIGITS-1:0]   an_sel;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = SEG_ERR;
    endcase
    if (HEX_MODE != 0) begin
      case (n)
        4'd10:   g = 7'b0001000;
        4'd11:   g = 7'b0000011;
        4'd12:   g = 7'b1000110;
        4'd13:   g = 7'b0100001;
        4'd14:   g = 7'b0000110;
        4'd15:   g = 7'b0001110;
        default: g = g;
      endcase
    end
    return g;
  endfunction

  // upper_zero[i] is set when nibbles i..DIGITS-1 are all zero
  always_comb begin
    zero_run   = 1'b1;
    upper_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run & (shadow_q[4*i +: 4] == 4'd0);
      upper_zero[i] = zero_run;
    end
  end

  always_comb begin
    nib      = 4'd0;
    cur_zero = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib      = shadow_q[4*i +: 4];
        cur_zero = upper_zero[i];
      end
    end
  end

  assign tick       = (pre_q == PRE_MAX);
  assign blank_slot = blank_lz && (idx_q != '0) && cur_zero;
  assign an_sel     = ~(DIGITS'(1) << idx_q);

  always_comb begin
    shadow_d = shadow_q;
    pre_d    = pre_q;
    idx_d    = idx_q;
    fd_d     = 1'b0;
    seg_d    = SEG_OFF;
    an_d     = '1;

    if (on && en) begin
      shadow_d = data;
    end

    if (!on) begin
      pre_d = '0;
      idx_d = '0;
    end else begin
      if (tick) begin
        pre_d = '0;
        idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        fd_d  = (idx_q == IDX_MAX);
      end else begin
        pre_d = pre_q + PW'(1);
      end

      // outputs reflect the slot currently held in idx_q, one cycle late
      if (set) begin
        seg_d = SEG_ALL;
        an_d  = an_sel;
      end else if (blank_slot) begin
        seg_d = SEG_OFF;
        an_d  = '1;
      end else begin
        seg_d = glyph(nib);
        an_d  = an_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= '0;
      pre_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_ZERO;
      an_q     <= ~DIGITS'(1);
      fd_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      fd_q     <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - scoreboard bench for seg_scan_driver
// Stimulus queues per-cycle expectations; a negedge monitor pops and compares.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        on = 1'b0, en = 1'b0, set = 1'b0, blank_lz = 1'b0;
  logic [15:0] data = 16'h0;
  logic [6:0]  seg, seg_h;
  logic [3:0]  an, an_h;
  logic        fd, fd_h;

  seg_scan_driver #(.DIGITS(4), .CLK_DIV(4), .HEX_MODE(0)) dut (
    .clk(clk), .rst(rst), .on(on), .en(en), .set(set), .blank_lz(blank_lz),
    .data(data), .seg(seg), .an(an), .frame_done(fd)
  );

  seg_scan_driver #(.DIGITS(4), .CLK_DIV(4), .HEX_MODE(1)) dut_h (
    .clk(clk), .rst(rst), .on(on), .en(en), .set(set), .blank_lz(blank_lz),
    .data(data), .seg(seg_h), .an(an_h), .frame_done(fd_h)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [6:0] seg;
    logic [6:0] hseg;
    logic [3:0] an;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  localparam logic [27:0] G1234 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
  localparam logic [27:0] G5678 = {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000};
  localparam logic [27:0] G0000 = {4{7'b1000000}};
  localparam logic [27:0] ZSEG  = 28'd0;
  localparam logic [15:0] AN_SCAN = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [15:0] AN_LZ3  = {4'b1111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [15:0] AN_LZ2  = {4'b1111, 4'b1111, 4'b1101, 4'b1110};
  localparam logic [15:0] AN_LZ1  = {4'b1111, 4'b1111, 4'b1111, 4'b1110};

  always @(negedge clk) begin : monitor
    exp_t e;
    while (q.size() > 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      n_vec++;
      if (e.c != cyc) begin
        $display("FAIL stale_entry cyc %0d expected at %0d", cyc, e.c);
        n_miss++;
      end else begin
        if (seg !== e.seg) begin
          $display("FAIL seg cyc %0d got %b want %b", cyc, seg, e.seg);
          n_miss++;
        end
        if (an !== e.an) begin
          $display("FAIL an cyc %0d got %b want %b", cyc, an, e.an);
          n_miss++;
        end
        if (fd !== e.fd) begin
          $display("FAIL frame_done cyc %0d got %b want %b", cyc, fd, e.fd);
          n_miss++;
        end
        if (seg_h !== e.hseg) begin
          $display("FAIL hex_seg cyc %0d got %b want %b", cyc, seg_h, e.hseg);
          n_miss++;
        end
        if (an_h !== e.an) begin
          $display("FAIL hex_an cyc %0d got %b want %b", cyc, an_h, e.an);
          n_miss++;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      $display("FAIL %s got %b want %b", nm, act, exp);
      n_miss++;
    end
  endtask

  task automatic push(input int c, input logic [6:0] s, input logic [6:0] hs,
                      input logic [3:0] a, input logic f);
    exp_t e;
    e.c = c; e.seg = s; e.hseg = hs; e.an = a; e.fd = f;
    q.push_back(e);
  endtask

  // j counts edges after base; edge base has prescaler=0 and idx=0
  task automatic push_range(input int base, input int j0, input int j1,
                            input logic [27:0] segs, input logic [27:0] hsegs,
                            input logic [15:0] ans);
    for (int j = j0; j <= j1; j++) begin
      int d;
      d = ((j - 1) / 4) % 4;
      push(base + j, segs[7*d +: 7], hsegs[7*d +: 7], ans[4*d +: 4], (j % 16) == 0);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic start(input logic [15:0] d, output int base);
    on = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    push(cyc, 7'h7F, 7'h7F, 4'hF, 1'b0);
    base = cyc;
    on = 1'b1; en = 1'b1; data = d;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  initial begin : stim
    int b;
    int r;
    int p;

    #1 rst = 1'b0;
    #1;
    chk("reset_seg", {1'b0, seg}, 8'b01000000);
    chk("reset_an", {4'h0, an}, 8'b00001110);
    chk("reset_fd", {7'h0, fd}, 8'h00);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // scan 1234, then change data with en low, then load on a tick edge
    start(16'h1234, b);
    data = 16'hFFFF;
    push_range(b, 2, 36, G1234, G1234, AN_SCAN);
    push_range(b, 37, 44, G5678, G5678, AN_SCAN);
    wait_until(b + 35);
    en = 1'b1; data = 16'h5678;
    wait_until(b + 36);
    en = 1'b0;

    // asynchronous reset mid-frame
    wait_until(b + 46);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_seg", {1'b0, seg}, 8'b01000000);
    chk("async_rst_an", {4'h0, an}, 8'b00001110);
    chk("async_rst_fd", {7'h0, fd}, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;
    r = cyc;
    push_range(r, 1, 8, G0000, G0000, AN_SCAN);
    wait_until(r + 8);

    // error glyph and leading-zero blanking
    blank_lz = 1'b1;
    start(16'h00A5, b);
    push_range(b, 2, 17, {7'h7F, 7'h7F, 7'b0111111, 7'b0010010},
               {7'h7F, 7'h7F, 7'b0001000, 7'b0010010}, AN_LZ2);
    wait_until(b + 17);

    start(16'h0987, b);
    push_range(b, 2, 17, {7'h7F, 7'b0010000, 7'b0000000, 7'b1111000},
               {7'h7F, 7'b0010000, 7'b0000000, 7'b1111000}, AN_LZ3);
    wait_until(b + 17);

    start(16'h0600, b);
    push_range(b, 2, 17, {7'h7F, 7'b0000010, 7'b1000000, 7'b1000000},
               {7'h7F, 7'b0000010, 7'b1000000, 7'b1000000}, AN_LZ3);
    wait_until(b + 17);

    blank_lz = 1'b0;
    start(16'hFEDB, b);
    push_range(b, 2, 17, {4{7'b0111111}},
               {7'b0001110, 7'b0000110, 7'b0100001, 7'b0000011}, AN_SCAN);
    wait_until(b + 17);

    blank_lz = 1'b1;
    start(16'h000C, b);
    push_range(b, 2, 17, {7'h7F, 7'h7F, 7'h7F, 7'b0111111},
               {7'h7F, 7'h7F, 7'h7F, 7'b1000110}, AN_LZ1);
    wait_until(b + 17);

    // lamp test, power drop during lamp test, power back up, set mid-slot
    blank_lz = 1'b0;
    set = 1'b1;
    start(16'h1234, b);
    push_range(b, 2, 18, ZSEG, ZSEG, AN_SCAN);
    for (int k = 19; k <= 21; k++) push(b + k, 7'h7F, 7'h7F, 4'hF, 1'b0);
    wait_until(b + 18);
    on = 1'b0;
    wait_until(b + 21);
    on = 1'b1; set = 1'b0;
    p = cyc;
    push_range(p, 1, 5, G1234, G1234, AN_SCAN);
    push_range(p, 6, 7, ZSEG, ZSEG, AN_SCAN);
    push_range(p, 8, 12, G1234, G1234, AN_SCAN);
    wait_until(p + 5);
    set = 1'b1;
    wait_until(p + 7);
    set = 1'b0;
    wait_until(p + 12);

    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      $display("FAIL drain %0d entries left, want 0", q.size());
      n_miss++;
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
